keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   press and the release of a single tracked key, and reports the key as a
//   4-bit hex code with a one-cycle valid strobe.
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     defined   -> a held key re-issues key_valid every REPEAT_CYCLES cycles
//     undefined -> exactly one key_valid per debounced press
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rows[3:0]    raw keypad rows, active-low, asynchronous to clk
//   cols[3:0]    column drives, active-low, exactly one bit low
//   key[3:0]     code of the last accepted key, held until the next accept
//   key_valid    one-cycle pulse per accepted key (and per repeat)
//   key_pressed  high from accept until the release is debounced
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 10000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int SW = $clog2(SCAN_CYCLES) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t          state, state_n;
  logic [1:0]      col_idx, col_n;
  logic [1:0]      row_idx, row_n;
  logic [SW-1:0]   dwell, dwell_n;
  logic [DW-1:0]   deb, deb_n;
  logic [3:0]      key_n;
  logic            key_valid_n, key_pressed_n;
  logic [3:0]      rows_m, rows_s;
  logic [1:0]      first_low;
  logic            any_low, row_low;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0]   rep, rep_n;
`else
  // REPEAT_CYCLES has no role when auto-repeat is compiled out.
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CYCLES != 0);
`endif

  // Hex code printed on the key at row r, column c.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;  4'hE: key_code = 4'hF;  default: key_code = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer; idle rows read as released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  assign cols    = ~(4'b0001 << col_idx);
  assign any_low = (rows_s != 4'hF);
  assign row_low = ~rows_s[row_idx];

  // Lowest-index low row wins when several keys in a column are down.
  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) first_low = 2'(i);
    end
  end

  // NOTE: combinational logic uses blocking assignments, and every output gets
  // a default first so no path leaves a value unassigned (no inferred latch).
  always_comb begin
    state_n       = state;
    col_n         = col_idx;
    row_n         = row_idx;
    dwell_n       = dwell;
    deb_n         = deb;
    key_n         = key;
    key_valid_n   = 1'b0;
    key_pressed_n = key_pressed;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n         = rep;
`endif
    case (state)
      SCAN: begin
        if (dwell == SCAN_LAST) begin
          dwell_n = '0;
          if (any_low) begin
            row_n   = first_low;
            deb_n   = '0;
            state_n = DEB_PRESS;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!row_low) begin
          col_n   = col_idx + 2'd1;
          dwell_n = '0;
          state_n = SCAN;
        end else if (deb == DEB_LAST) begin
          // This cycle is the DEBOUNCE_CYCLES-th consecutive low sample.
          key_n         = key_code(row_idx, col_idx);
          key_valid_n   = 1'b1;
          key_pressed_n = 1'b1;
          state_n       = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n         = '0;
`endif
        end else begin
          deb_n = deb + 1'b1;
        end
      end
      HELD: begin
        if (!row_low) begin
          deb_n   = '0;
          state_n = DEB_REL;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n   = '0;
`endif
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep == REP_LAST) begin
          key_valid_n = 1'b1;
          rep_n       = '0;
        end else begin
          rep_n = rep + 1'b1;
        end
`endif
      end
      default: begin // DEB_REL
        if (row_low) begin
          // Bounce: back to HELD; the repeat interval starts over.
          state_n = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n   = '0;
`endif
        end else if (deb == DEB_LAST) begin
          key_pressed_n = 1'b0;
          col_n         = col_idx + 2'd1;
          dwell_n       = '0;
          state_n       = SCAN;
        end else begin
          deb_n = deb + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      dwell       <= '0;
      deb         <= '0;
      key         <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep         <= '0;
`endif
    end else begin
      state       <= state_n;
      col_idx     <= col_n;
      row_idx     <= row_n;
      dwell       <= dwell_n;
      deb         <= deb_n;
      key         <= key_n;
      key_valid   <= key_valid_n;
      key_pressed <= key_pressed_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep         <= rep_n;
`endif
    end
  end

endmodule
